// File: rtl/fft_frame_collector.sv
// Serial-to-parallel collector for the 16-point FFT: gathers 16 complex samples into a
// shadow buffer (optionally bit-reversed slot order) and publishes whole frames with a strobe.

module fft_frame_slot #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 ld,
  input  logic                 sel,
  input  logic [WORD_SIZE-1:0] d_re,
  input  logic [WORD_SIZE-1:0] d_im,
  output logic [WORD_SIZE-1:0] q_re,
  output logic [WORD_SIZE-1:0] q_im
);
  logic [WORD_SIZE-1:0] sh_re, sh_im;

  // On the completing accept the incoming sample bypasses the shadow into the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_re <= '0;
      sh_im <= '0;
      q_re  <= '0;
      q_im  <= '0;
    end else begin
      if (wr) begin
        sh_re <= d_re;
        sh_im <= d_im;
      end
      if (ld) begin
        q_re <= sel ? d_re : sh_re;
        q_im <= sel ? d_im : sh_im;
      end
    end
  end
endmodule

module fft_frame_collector #(
  parameter int WORD_SIZE = 16,
  parameter int BITREV    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_SIZE-1:0]    in_re,
  input  logic [WORD_SIZE-1:0]    in_im,
  input  logic                    in_sof,
  output logic [16*WORD_SIZE-1:0] out_re,
  output logic [16*WORD_SIZE-1:0] out_im,
  output logic                    we,
  output logic [7:0]              frame_cnt,
  output logic                    sof_err
);
  localparam int SLOTS = 16;

  logic [3:0] wr_cnt;
  logic [3:0] slot;
  logic       acc;
  logic       cmpl;
  logic [1:0] strb_pipe;

  assign acc  = in_valid & in_ready;
  assign cmpl = acc & ~in_sof & (wr_cnt == 4'd15);
  assign we   = strb_pipe[1];

  always_comb begin
    slot = wr_cnt;
    if (BITREV != 0) slot = {wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3]};
    if (in_sof)      slot = 4'd0;
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic hit;
    assign hit = (slot == 4'(i));
    fft_frame_slot #(.WORD_SIZE(WORD_SIZE)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .wr   (acc & hit),
      .ld   (cmpl),
      .sel  (hit),
      .d_re (in_re),
      .d_im (in_im),
      .q_re (out_re[i*WORD_SIZE +: WORD_SIZE]),
      .q_im (out_im[i*WORD_SIZE +: WORD_SIZE])
    );
  end

  // Strobe trails the bus load by one edge so the consumer sees settled data.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      wr_cnt    <= '0;
      frame_cnt <= '0;
      sof_err   <= 1'b0;
      strb_pipe <= '0;
    end else begin
      in_ready  <= 1'b1;
      strb_pipe <= {strb_pipe[0], cmpl};
      if (acc) begin
        if (in_sof) begin
          wr_cnt <= 4'd1;
          if (wr_cnt != 4'd0) sof_err <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end
      if (cmpl) frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_fft_frame_collector.sv
// Randomized self-checking bench; runs BITREV=0 and BITREV=1 collectors side by side
// against a frame-level reference model.

module tb_fft_frame_collector;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof;
  logic [W-1:0] in_re, in_im;
  logic rdy0, rdy1, we0, we1, se0, se1;
  logic [16*W-1:0] ore0, oim0, ore1, oim1;
  logic [7:0] fc0, fc1;

  always #5 clk = ~clk;

  fft_frame_collector #(.WORD_SIZE(W), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_re(in_re), .in_im(in_im),
    .in_sof(in_sof), .out_re(ore0), .out_im(oim0), .we(we0), .frame_cnt(fc0), .sof_err(se0));
  fft_frame_collector #(.WORD_SIZE(W), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_re(in_re), .in_im(in_im),
    .in_sof(in_sof), .out_re(ore1), .out_im(oim1), .we(we1), .frame_cnt(fc1), .sof_err(se1));

  int tests = 0, fails = 0;

  // reference model: frame indexed by sample number, outputs published per completed frame
  int n;
  logic [W-1:0] fr_re[16], fr_im[16];
  logic [W-1:0] x_re0[16], x_im0[16], x_re1[16], x_im1[16];
  bit m_rdy, m_err, m_pend, m_we;
  int m_cnt;

  function automatic int brv(int i);
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction

  function automatic logic [16*W-1:0] pk(input logic [W-1:0] a[16]);
    logic [16*W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*W +: W] = a[i];
    return v;
  endfunction

  task automatic tick();
    bit done;
    done = 0;
    if (rst) begin
      n = 0; m_err = 0; m_rdy = 0; m_pend = 0; m_we = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        x_re0[i] = '0; x_im0[i] = '0; x_re1[i] = '0; x_im1[i] = '0;
      end
    end else begin
      if (in_valid && m_rdy) begin
        if (in_sof) begin
          if (n != 0) m_err = 1;
          fr_re[0] = in_re; fr_im[0] = in_im; n = 1;
        end else begin
          fr_re[n] = in_re; fr_im[n] = in_im; n++;
          if (n == 16) begin n = 0; done = 1; end
        end
      end
      m_we = m_pend;
      m_pend = done;
      if (done) begin
        for (int i = 0; i < 16; i++) begin
          x_re0[i] = fr_re[i]; x_im0[i] = fr_im[i];
          x_re1[brv(i)] = fr_re[i]; x_im1[brv(i)] = fr_im[i];
        end
        m_cnt = (m_cnt + 1) % 256;
      end
      m_rdy = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(bit v, bit sof, logic [W-1:0] re, logic [W-1:0] im);
    in_valid = v; in_sof = sof; in_re = re; in_im = im;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_sof = 0; in_re = '0; in_im = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if ({ore0, oim0, ore1, oim1} !== '0 || {we0, we1, se0, se1, rdy0, rdy1} !== 6'b0 ||
          {fc0, fc1} !== 16'd0) begin
        fails++;
        $display("FAIL reset_state: we=%b%b se=%b%b rdy=%b%b fc=%0d/%0d (required all 0)",
                 we0, we1, se0, se1, rdy0, rdy1, fc0, fc1);
      end
    end
    rst = 0;
    tick();
    tests++;
    if ({rdy0, rdy1} !== {m_rdy, m_rdy} || m_rdy !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: rdy=%b%b required 11", rdy0, rdy1);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if ({we0, we1} !== 2'b00) begin
        fails++; $display("FAIL idle_we: we=%b%b required 00", we0, we1);
      end
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] lin[16];
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, W'(i), W'(-i));
      tests++;
      if ({we0, we1} !== {m_we, m_we}) begin
        fails++; $display("FAIL frame_we_early: cyc %0d we=%b%b required %b%b", i, we0, we1, m_we, m_we);
      end
    end
    drive(0, 0, '0, '0);
    tests++;
    if ({we0, we1} !== 2'b11 || m_we !== 1'b1) begin
      fails++; $display("FAIL frame_we_pulse: we=%b%b required 11", we0, we1);
    end
    for (int i = 0; i < 16; i++) lin[i] = W'(i);
    tests++;
    if (ore0 !== pk(lin) || ore0 !== pk(x_re0) || oim0 !== pk(x_im0)) begin
      fails++; $display("FAIL frame_lin_bus: re=%h required %h", ore0, pk(lin));
    end
    tests++;
    if (ore1[1*W +: W] !== 16'd8 || ore1[3*W +: W] !== 16'd12 || ore1[15*W +: W] !== 16'd15 ||
        ore1 !== pk(x_re1) || oim1 !== pk(x_im1)) begin
      fails++; $display("FAIL frame_bitrev_bus: re=%h required %h", ore1, pk(x_re1));
    end
    tests++;
    if (fc0 !== 8'd1 || fc1 !== 8'd1) begin
      fails++; $display("FAIL frame_cnt1: fc=%0d/%0d required 1", fc0, fc1);
    end
    drive(0, 0, '0, '0);
    tests++;
    if ({we0, we1} !== 2'b00) begin
      fails++; $display("FAIL frame_we_width: we=%b%b required 00", we0, we1);
    end
  endtask

  task automatic test_sof_err();
    int pulses = 0;
    for (int i = 0; i < 7; i++) drive(1, 0, W'($urandom), W'($urandom));
    drive(1, 1, 16'h1234, W'($urandom));
    for (int i = 0; i < 17; i++) begin
      if (i < 15) drive(1, 0, W'($urandom), W'($urandom));
      else drive(0, 0, '0, '0);
      if (we0) pulses++;
    end
    tests++;
    if ({se0, se1} !== 2'b11 || m_err !== 1'b1) begin
      fails++; $display("FAIL sof_err_flag: se=%b%b required 11", se0, se1);
    end
    tests++;
    if (pulses !== 1) begin
      fails++; $display("FAIL sof_single_we: pulses=%0d required 1", pulses);
    end
    tests++;
    if (ore0[0 +: W] !== 16'h1234 || ore1[0 +: W] !== 16'h1234 || ore0 !== pk(x_re0) ||
        oim0 !== pk(x_im0) || ore1 !== pk(x_re1) || oim1 !== pk(x_im1)) begin
      fails++; $display("FAIL sof_frame: slot0=%h/%h required 1234", ore0[0 +: W], ore1[0 +: W]);
    end
  endtask

  task automatic test_gaps();
    int k = 0, guard = 0;
    logic [W-1:0] lr[16], li[16];
    while (k < 16 && guard < 200) begin
      guard++;
      if ($urandom_range(1) == 1) begin drive(1, 0, W'(k), W'(-k)); k++; end
      else drive(0, 0, W'($urandom), W'($urandom));
      tests++;
      if (ore0 !== pk(x_re0) || oim0 !== pk(x_im0) || ore1 !== pk(x_re1) || oim1 !== pk(x_im1) ||
          {we0, we1} !== {m_we, m_we}) begin
        fails++; $display("FAIL gaps_bus_hold: k=%0d re=%h required %h we=%b", k, ore0, pk(x_re0), we0);
      end
    end
    drive(0, 0, '0, '0);
    for (int i = 0; i < 16; i++) begin lr[i] = W'(i); li[i] = W'(-i); end
    tests++;
    if (ore0 !== pk(lr) || oim0 !== pk(li) || k != 16) begin
      fails++; $display("FAIL gaps_frame: re=%h required %h", ore0, pk(lr));
    end
  endtask

  task automatic test_rst_mid();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, W'($urandom), W'($urandom));
      if (we0 || we1) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++; $display("FAIL rst_mid_early_we: pulses=%0d required 0", pulses);
    end
    rst = 1; drive(0, 0, '0, '0);
    rst = 0; drive(0, 0, '0, '0);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1, 0, W'($urandom), W'($urandom));
      else drive(0, 0, '0, '0);
      if (we0) pulses++;
    end
    tests++;
    if (pulses !== 1 || fc0 !== 8'd1 || fc1 !== 8'd1 || {se0, se1} !== 2'b00) begin
      fails++; $display("FAIL rst_mid_frame: pulses=%0d fc=%0d se=%b required 1,1,0", pulses, fc0, se0);
    end
    tests++;
    if (ore0 !== pk(x_re0) || oim0 !== pk(x_im0) || ore1 !== pk(x_re1) || oim1 !== pk(x_im1)) begin
      fails++; $display("FAIL rst_mid_bus: re=%h required %h", ore0, pk(x_re0));
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, bad = 0;
    bit prev = 0;
    for (int f = 0; f < 299; f++)
      for (int i = 0; i < 16; i++) begin
        drive(1, 0, W'($urandom), W'($urandom));
        if (we0) pulses++;
        if ((we0 && prev) || we0 !== m_we || we1 !== m_we) bad++;
        prev = we0;
      end
    drive(0, 0, '0, '0);
    if (we0) pulses++;
    tests++;
    if (bad != 0 || pulses != 299) begin
      fails++; $display("FAIL b2b_we: pulses=%0d bad=%0d required 299,0", pulses, bad);
    end
    tests++;
    if (fc0 !== 8'd44 || fc1 !== 8'd44 || m_cnt != 44) begin
      fails++; $display("FAIL b2b_wrap: fc=%0d/%0d required 44", fc0, fc1);
    end
    tests++;
    if (ore0 !== pk(x_re0) || oim0 !== pk(x_im0) || ore1 !== pk(x_re1) || oim1 !== pk(x_im1)) begin
      fails++; $display("FAIL b2b_bus: re=%h required %h", ore1, pk(x_re1));
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_sof_err();
    test_gaps();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
